pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Unified hazard, forwarding and flush controller for the 5-stage RISC-V pipeline.
//  Generalises the old split hazard/forwarding units: parametrised register-address width,
//  multi-cycle EX ops (MUL/DIV) held in EX by an internal latency FSM, and taken-branch flush of IF/ID/EX.
//  Sits beside the pipeline registers; drives their write-enables, bubble and flush inputs, and the ALU operand muxes.
// PARAMETERS
//  RA_W     5   register-address width (x0 = all-zero address, never hazards or forwards)
//  MC_LAT   4   total cycles a multi-cycle op occupies EX; legal range 2..255
//  CNT_W    8   width of the MC latency counter
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     synchronous, active-high
//  id_rs1,id_rs2  in   RA_W  source regs of instr in ID
//  id_rs1_used    in   1     instr in ID reads rs1
//  id_rs2_used    in   1     instr in ID reads rs2
//  ex_rs1,ex_rs2  in   RA_W  source regs of instr in EX
//  ex_rd          in   RA_W  dest of instr in EX
//  ex_memread     in   1     EX instr is a load
//  ex_mc_op       in   1     EX instr is multi-cycle (level while it sits in EX)
//  mem_rd         in   RA_W  dest in MEM;  mem_regwrite in 1;  mem_memtoreg in 1
//  wb_rd          in   RA_W  dest in WB;   wb_regwrite  in 1
//  branch_taken   in   1     resolved taken branch in MEM
//  pc_write       out  1     PC load enable
//  ifid_write     out  1     IF/ID load enable
//  idex_write     out  1     ID/EX load enable
//  idex_bubble    out  1     zero ID/EX control fields
//  exmem_bubble   out  1     zero EX/MEM control fields
//  flush          out  1     clear IF/ID, ID/EX, EX/MEM contents
//  fwd_a,fwd_b    out  2     ALU operand select: 00 regfile, 01 WB result, 10 EX/MEM ALU result
//  mc_done        out  1     final EX cycle of a multi-cycle op
// BEHAVIOUR
//  - Registered state: FSM {IDLE,BUSY} and cnt[CNT_W]; all outputs combinational from state + inputs.
//  - Reset (sampled high at edge): state=IDLE, cnt=0. While reset is high: pc_write=ifid_write=idex_write=0,
//    flush=1, bubbles=0, fwd_a=fwd_b=00, mc_done=0.
//  - Forwarding, per operand (rs = ex_rs1/ex_rs2): rs==0 -> 00; else mem_regwrite & !mem_memtoreg
//    & mem_rd==rs -> 10; else wb_regwrite & wb_rd==rs -> 01; else 00. MEM beats WB on double match.
//  - Load-use: ex_memread & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
//    -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
//  - mc_stall = ex_mc_op & !(state==BUSY & cnt==0).
//    IDLE: ex_mc_op & !branch_taken -> BUSY, cnt=MC_LAT-2.
//    BUSY: cnt==0 -> IDLE, mc_done=1; else cnt-=1.
//    While mc_stall: pc_write=ifid_write=idex_write=0, exmem_bubble=1. Op leaves EX after MC_LAT cycles total.
//  - Priority: flush > mc_stall > load-use. Under mc_stall idex_bubble=0 (ID/EX frozen, load-use ignored).
//  - branch_taken: flush=1, pc_write=1, all stall/bubble outputs 0; FSM forced IDLE, cnt=0 (wrong-path MC op aborted).
//  - Default (no event): all write enables 1, bubbles 0, flush 0.
//  - ex_mc_op dropping while BUSY (flushed/aborted upstream) -> IDLE next cycle, no mc_done.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cycles[31:0], flush_count[31:0]; reset to 0;
//    stall_cycles += 1 each cycle with pc_write=0 and !flush; flush_count += 1 per branch_taken cycle;
//    both saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  hazard_pkg: fwd-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state encoding; MC_LAT bounds.
//  Sub-module hazard_fwd_sel: single-operand forwarding comparator, instantiated for A and B.
//  FSM, stall/flush priority logic and optional perf counters stay in the top.
// TESTING
//  1) ex_rs1=3, mem_rd=3 mem_regwrite=1, wb_rd=3 wb_regwrite=1 -> fwd_a=10; ex_rs1=0 same setup -> fwd_a=00.
//  2) ex_memread=1 ex_rd=5, id_rs2=5 id_rs2_used=1 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle clear.
//  3) MC_LAT=4, ex_mc_op high from cycle t -> stall cycles t..t+2, mc_done=1 and stall=0 at t+3, state IDLE at t+4.
//  4) MC op in BUSY cnt=1, branch_taken=1 -> flush=1 same cycle, pc_write=1, next state IDLE, no mc_done.
//  5) load-use match during BUSY -> idex_bubble=0, idex_write=0; reset asserted mid-BUSY -> next cycle IDLE, flush=1 while high.
//  6) HAZARD_PERF_EN: 3 load-use stalls + 2 taken branches -> stall_cycles=3, flush_count=2; reset -> both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forwarding-select encodings, multi-cycle FSM state encoding and the
// legal multi-cycle latency range.
package hazard_pkg;

    // ALU operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // WB-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

    // Multi-cycle latency bounds (total EX occupancy in cycles)
    localparam int MC_LAT_MIN = 2;
    localparam int MC_LAT_MAX = 255;

    // Multi-cycle op tracking FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding comparator. Picks the youngest in-flight
// producer of the EX-stage source register; x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memtoreg,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic [1:0]      fwd_sel
);

    // MEM is younger than WB, so it wins a double match. A load in MEM has
    // no data yet (load-use stall covers it), so it is not a forward source.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_rs != '0) begin
            if (mem_regwrite && !mem_memtoreg && (mem_rd == ex_rs))
                fwd_sel = FWD_MEM;
            else if (wb_regwrite && (wb_rd == ex_rs))
                fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Unified hazard, forwarding and flush controller for the 5-stage pipeline.
// Handles ALU operand forwarding, load-use stalls, multi-cycle EX ops held
// by a latency FSM, and taken-branch flush. Outputs are combinational from
// the FSM state and the current pipeline inputs.
// Optional: define HAZARD_PERF_EN to add stall_cycles / flush_count
// saturating performance counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic            ex_mc_op,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memtoreg,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic            branch_taken,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_write,
    output logic            idex_bubble,
    output logic            exmem_bubble,
    output logic            flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mc_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    // Reject latencies the down-counter cannot represent or that make no sense
    if (MC_LAT < MC_LAT_MIN || MC_LAT > MC_LAT_MAX) begin : g_bad_lat
        $error("pipe_hazard_ctrl: MC_LAT out of range");
    end
    if ((MC_LAT - 2) >= (2 ** CNT_W)) begin : g_bad_cnt
        $error("pipe_hazard_ctrl: CNT_W too narrow for MC_LAT");
    end

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LAT - 2);

    hz_state_e        state;
    logic [CNT_W-1:0] cnt;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       mc_last;
    logic       mc_stall;
    logic       load_use;

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_sel      (sel_a)
    );

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_sel      (sel_b)
    );

    // Hazard detection terms. The first cycle of an MC op is spent in IDLE,
    // so BUSY with cnt==0 is the final EX cycle and releases the stall.
    always_comb begin
        mc_last  = (state == ST_BUSY) && (cnt == '0);
        mc_stall = ex_mc_op && !mc_last;
        load_use = ex_memread && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Pipeline control with priority reset > flush > mc_stall > load-use
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        flush        = 1'b0;
        mc_done      = 1'b0;
        fwd_a        = sel_a;
        fwd_b        = sel_b;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            flush      = 1'b1;
            fwd_a      = FWD_RF;
            fwd_b      = FWD_RF;
        end else if (branch_taken) begin
            flush = 1'b1;
        end else if (mc_stall) begin
            // ID/EX stays frozen, so any load-use in ID simply waits
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else begin
            mc_done = ex_mc_op && mc_last;
            if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Multi-cycle latency FSM; a taken branch aborts a wrong-path MC op
    always_ff @(posedge clk) begin
        if (reset || branch_taken) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_mc_op) begin
                        state <= ST_BUSY;
                        cnt   <= CNT_START;
                    end
                end
                ST_BUSY: begin
                    if (!ex_mc_op || (cnt == '0)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters: frontend stall cycles and taken-branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && !flush && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run, all checked against an age-based behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int RA_W   = 5;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_rs1_used, id_rs2_used, ex_memread, ex_mc_op;
    logic            mem_regwrite, mem_memtoreg, wb_regwrite, branch_taken;
    logic            pc_write, ifid_write, idex_write, idex_bubble;
    logic            exmem_bubble, flush, mc_done;
    logic [1:0]      fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(.RA_W(RA_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mc_op(ex_mc_op),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_done(mc_done)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state: how many earlier consecutive cycles the current MC op has sat in EX
    int          m_age;
    logic [31:0] m_stall_cycles, m_flush_count;
    // Expected outputs for the current cycle
    logic e_pcw, e_ifid, e_idex, e_ib, e_eb, e_flush, e_done;
    logic [1:0] e_fa, e_fb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_regwrite && !mem_memtoreg && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Derive expected outputs from the rules, then compare every output
    task automatic model_check();
        logic stall, lu;
        {e_pcw, e_ifid, e_idex, e_ib, e_eb, e_flush, e_done} = 7'b1110000;
        e_fa = 2'b00; e_fb = 2'b00;
        if (reset) begin
            {e_pcw, e_ifid, e_idex} = 3'b000;
            e_flush = 1'b1;
        end else begin
            e_fa = m_fwd(ex_rs1);
            e_fb = m_fwd(ex_rs2);
            stall = ex_mc_op && (m_age != MC_LAT - 1);
            lu = ex_memread && ex_rd != 0 &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
            if (branch_taken) e_flush = 1'b1;
            else if (stall) begin
                {e_pcw, e_ifid, e_idex} = 3'b000;
                e_eb = 1'b1;
            end else begin
                e_done = ex_mc_op;
                if (lu) begin
                    {e_pcw, e_ifid} = 2'b00;
                    e_ib = 1'b1;
                end
            end
        end
        chk("pc_write", pc_write, e_pcw);
        chk("ifid_write", ifid_write, e_ifid);
        chk("idex_write", idex_write, e_idex);
        chk("idex_bubble", idex_bubble, e_ib);
        chk("exmem_bubble", exmem_bubble, e_eb);
        chk("flush", flush, e_flush);
        chk("mc_done", mc_done, e_done);
        chk("fwd_a", fwd_a, e_fa);
        chk("fwd_b", fwd_b, e_fb);
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall_cycles);
        chk("flush_count", flush_count, m_flush_count);
`endif
    endtask

    // Advance model state with the inputs the DUT samples at the next edge
    task automatic model_step();
        if (reset || branch_taken || !ex_mc_op || m_age == MC_LAT - 1) m_age = 0;
        else m_age = m_age + 1;
        if (reset) begin
            m_stall_cycles = 0;
            m_flush_count  = 0;
        end else begin
            if (!e_pcw && !e_flush && m_stall_cycles != 32'hFFFF_FFFF) m_stall_cycles++;
            if (branch_taken && m_flush_count != 32'hFFFF_FFFF) m_flush_count++;
        end
    endtask

    // Inputs are applied 1 time unit after posedge; sample at the negedge
    task automatic sample();
        #4;
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        reset = 0;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_memread, ex_mc_op} = '0;
        {mem_regwrite, mem_memtoreg, wb_regwrite, branch_taken} = '0;
    endtask

    int mc_left;

    initial begin
        m_age = 0; m_stall_cycles = 0; m_flush_count = 0;
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        // Reset state
        sample();
        chk("rst_flush", flush, 1'b1);
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        advance();
        idle_inputs();
        cyc();

        // 1) forwarding priority and x0
        ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
        sample(); chk("t1_mem_beats_wb", fwd_a, 2'b10); advance();
        ex_rs1 = 0;
        sample(); chk("t1_x0", fwd_a, 2'b00); advance();
        ex_rs2 = 3; mem_memtoreg = 1;
        sample(); chk("t1_load_in_mem_wb", fwd_b, 2'b01); advance();
        idle_inputs();

        // 2) load-use single cycle stall
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        sample();
        chk("t2_pc_write", pc_write, 1'b0);
        chk("t2_ifid_write", ifid_write, 1'b0);
        chk("t2_idex_bubble", idex_bubble, 1'b1);
        advance();
        ex_memread = 0; ex_rd = 0;
        sample(); chk("t2_clear", {pc_write, idex_bubble}, 2'b10); advance();
        idle_inputs();

        // 3) MC op latency
        ex_mc_op = 1;
        for (int i = 0; i < MC_LAT - 1; i++) begin
            sample();
            chk("t3_stall", {pc_write, exmem_bubble, mc_done}, 3'b010);
            advance();
        end
        sample(); chk("t3_done", {pc_write, exmem_bubble, mc_done}, 3'b101); advance();
        sample(); chk("t3_idle_restart", {pc_write, mc_done}, 2'b00); advance();
        ex_mc_op = 0;
        cyc();

        // 4) branch aborts MC op in BUSY cnt=1
        ex_mc_op = 1;
        cyc(); cyc();
        branch_taken = 1;
        sample(); chk("t4_branch", {flush, pc_write, mc_done, exmem_bubble}, 4'b1100); advance();
        branch_taken = 0;
        sample(); chk("t4_idle_after", {pc_write, mc_done}, 2'b00); advance();
        ex_mc_op = 0;
        cyc();

        // 5) load-use during BUSY, then reset mid-BUSY
        ex_mc_op = 1;
        cyc();
        ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
        sample(); chk("t5_lu_in_busy", {idex_bubble, idex_write}, 2'b00); advance();
        reset = 1;
        sample(); chk("t5_reset_flush", {flush, pc_write}, 2'b10); advance();
        reset = 0; ex_memread = 0;
        sample(); chk("t5_idle_after_rst", {pc_write, mc_done}, 2'b00); advance();
        ex_mc_op = 0;
        cyc();

`ifdef HAZARD_PERF_EN
        // 6) perf counters
        reset = 1; cyc(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 1;
            cyc();
            idle_inputs(); cyc();
        end
        for (int i = 0; i < 2; i++) begin
            branch_taken = 1; cyc();
            branch_taken = 0; cyc();
        end
        sample();
        chk("t6_stall_cycles", stall_cycles, 32'd3);
        chk("t6_flush_count", flush_count, 32'd2);
        advance();
        reset = 1; cyc(); reset = 0;
        sample(); chk("t6_rst_counters", {stall_cycles, flush_count}, 64'd0); advance();
`endif

        // Randomized run
        idle_inputs();
        mc_left = 0;
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 79) == 0);
            branch_taken = ($urandom_range(0, 11) == 0);
            id_rs1 = RA_W'($urandom_range(0, 3)); id_rs2 = RA_W'($urandom_range(0, 3));
            ex_rs1 = RA_W'($urandom_range(0, 3)); ex_rs2 = RA_W'($urandom_range(0, 3));
            ex_rd  = RA_W'($urandom_range(0, 3)); mem_rd = RA_W'($urandom_range(0, 3));
            wb_rd  = RA_W'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom); id_rs2_used  = 1'($urandom);
            ex_memread   = 1'($urandom); mem_regwrite = 1'($urandom);
            mem_memtoreg = 1'($urandom); wb_regwrite  = 1'($urandom);
            if (mc_left == 0 && $urandom_range(0, 5) == 0) mc_left = $urandom_range(1, 7);
            ex_mc_op = (mc_left > 0);
            if (mc_left > 0) mc_left--;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
